// File: rtl/ahbl_apb_pkg.sv
// Shared constants, FSM state encoding and APB4 strobe decode for the AHB-Lite to APB bridge.
package ahbl_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Byte lanes touched by an access of the given size at the given word offset.
  function automatic logic [3:0] calc_pstrb(input logic [2:0] hsize, input logic [1:0] addr_lsbs);
    logic [3:0] strb;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr_lsbs;
      HSIZE_HALF: strb = 4'b0011 << {addr_lsbs[1], 1'b0};
      default:    strb = 4'hf;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahbl_to_apb_bridge.sv
// AHB-Lite subordinate to APB requester bridge, one APB transfer in flight.
// Define AHBL_TO_APB_APB4_EN to add the APB4 pstrb/pprot outputs.
module ahbl_to_apb_bridge
  import ahbl_apb_pkg::*;
#(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ahbls_hready_resp,
  input  logic               ahbls_hready,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [2:0]         ahbls_hburst,
  input  logic [3:0]         ahbls_hprot,
  input  logic               ahbls_hmastlock,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,
  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
`ifdef AHBL_TO_APB_APB4_EN
  output logic [3:0]         apbm_pstrb,
  output logic [2:0]         apbm_pprot,
`endif
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr
);

  // Handshake: an AHB transfer is accepted when ahbls_hready && htrans[1]
  // while this bridge reports hready_resp=1 (IDLE/ERR2); the data phase then
  // stalls until the APB transfer completes with pready=1 in ACCESS.

  state_t               state_q, state_d;
  logic [W_PADDR-1:0]   paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [W_DATA-1:0]    pwdata_q, pwdata_d;
  logic [W_DATA-1:0]    hrdata_q, hrdata_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 hready_resp_q, hready_resp_d;
  logic                 hresp_q, hresp_d;
  logic                 accept;

`ifdef AHBL_TO_APB_APB4_EN
  logic [3:0]           pstrb_q, pstrb_d;
  logic [2:0]           pprot_q, pprot_d;
  logic                 unused_ok;
  assign unused_ok = ^{ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_htrans[0], ahbls_hburst,
                       ahbls_hprot[3:2], ahbls_hmastlock};
`else
  logic                 unused_ok;
  assign unused_ok = ^{ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_htrans[0], ahbls_hsize,
                       ahbls_hburst, ahbls_hprot, ahbls_hmastlock};
`endif

  assign accept = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) &&
                  ahbls_hready && ahbls_htrans[1];

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
`ifdef AHBL_TO_APB_APB4_EN
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          state_d  = ahbls_hwrite ? ST_WDATA : ST_SETUP;
          paddr_d  = ahbls_haddr[W_PADDR-1:0];
          pwrite_d = ahbls_hwrite;
`ifdef AHBL_TO_APB_APB4_EN
          pstrb_d  = ahbls_hwrite ? calc_pstrb(ahbls_hsize, ahbls_haddr[1:0]) : 4'h0;
          pprot_d  = {~ahbls_hprot[0], 1'b0, ahbls_hprot[1]};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        pwdata_d = ahbls_hwdata;
        state_d  = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (apbm_pready) begin
          if (apbm_pslverr) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_IDLE;
            if (!pwrite_q) hrdata_d = apbm_prdata;
          end
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    hready_resp_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d       = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    psel_d        = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d     = (state_d == ST_ACCESS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      hrdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      hready_resp_q <= 1'b1;
      hresp_q       <= 1'b0;
`ifdef AHBL_TO_APB_APB4_EN
      pstrb_q       <= 4'h0;
      pprot_q       <= 3'h0;
`endif
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      hrdata_q      <= hrdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      hready_resp_q <= hready_resp_d;
      hresp_q       <= hresp_d;
`ifdef AHBL_TO_APB_APB4_EN
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
`endif
    end
  end

  assign ahbls_hready_resp = hready_resp_q;
  assign ahbls_hresp       = hresp_q;
  assign ahbls_hrdata      = hrdata_q;
  assign apbm_paddr        = paddr_q;
  assign apbm_psel         = psel_q;
  assign apbm_penable      = penable_q;
  assign apbm_pwrite       = pwrite_q;
  assign apbm_pwdata       = pwdata_q;
`ifdef AHBL_TO_APB_APB4_EN
  assign apbm_pstrb        = pstrb_q;
  assign apbm_pprot        = pprot_q;
`endif

endmodule

// File: doc/ahbl_to_apb_bridge.md
Name: ahbl_to_apb_bridge

Overview:
- AHB-Lite subordinate to APB requester bridge.
- Sits downstream of the system AHB-Lite fabric (CPU data/instruction port), beside the SRAM subordinate.
- Carries CPU and debug accesses to low-speed peripherals: UART, GPIO, timers, pad control.
- One APB transfer in flight; the AHB data phase is stalled until APB completion; APB errors are converted to the two-cycle AHB ERROR response.

Parameters:
- W_HADDR, 32: AHB address width.
- W_PADDR, 16: APB address width; paddr = haddr[W_PADDR-1:0].
- W_DATA, 32: data width, both buses. Only 32 is supported.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ahbls_hready_resp  output  1  subordinate ready (data phase done).
- ahbls_hready  input  1  bus-wide hready.
- ahbls_hresp  output  1  1 = ERROR.
- ahbls_haddr  input  W_HADDR  address.
- ahbls_hwrite  input  1  write.
- ahbls_htrans  input  2  transfer type.
- ahbls_hsize  input  3  size.
- ahbls_hburst  input  3  ignored.
- ahbls_hprot  input  4  protection.
- ahbls_hmastlock  input  1  ignored.
- ahbls_hwdata  input  W_DATA  write data.
- ahbls_hrdata  output  W_DATA  read data.
- apbm_paddr  output  W_PADDR  APB address.
- apbm_psel  output  1  select.
- apbm_penable  output  1  enable.
- apbm_pwrite  output  1  write.
- apbm_pwdata  output  W_DATA  write data.
- apbm_prdata  input  W_DATA  read data.
- apbm_pready  input  1  ready.
- apbm_pslverr  input  1  error.

Behaviour:
- Reset values (all outputs registered):
  - hready_resp=1, hresp=0, hrdata=0.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - State=IDLE.
  - Async reset mid-transfer aborts immediately. The APB side sees psel drop; no completion is issued.
- Accept condition: ahbls_hready && htrans[1] (NONSEQ/SEQ), only in states IDLE or ERR2 (the states with hready_resp=1).
  - On accept, latch haddr[W_PADDR-1:0] and hwrite.
  - IDLE/BUSY htrans: ignored; hready_resp stays 1, hresp 0, zero wait states.
- States:
  - IDLE: hready_resp=1.
    - Accept read -> SETUP.
    - Accept write -> WDATA.
  - WDATA: hready_resp=0. Latch ahbls_hwdata into pwdata -> SETUP.
  - SETUP: psel=1, penable=0 -> ACCESS.
  - ACCESS: psel=1, penable=1. Hold while !pready.
    - pready && !pslverr -> IDLE. Register hrdata=prdata on reads; hrdata is unchanged on writes.
    - pready && pslverr -> ERR1.
  - ERR1: hready_resp=0, hresp=1, psel=0 -> ERR2.
  - ERR2: hready_resp=1, hresp=1. Accept possible (same transitions as IDLE); otherwise -> IDLE.
- Latency, address phase in cycle 0, pready=1 on first ACCESS cycle:
  - Read: SETUP c1, ACCESS c2, hready_resp=1 with hrdata valid c3 (2 wait states).
  - Write: WDATA c1, SETUP c2, ACCESS c3, done c4 (3 wait states).
- No timeout: pready low indefinitely stalls AHB indefinitely.
- paddr and pwrite stay stable from SETUP through the end of ACCESS.
- psel deasserts the cycle after pready unless the transfer is back-to-back, in which case it passes through IDLE first. This gives a minimum of 1 cycle with psel=0 between APB transfers.
- hsize and haddr[1:0] are not checked. Sub-word writes write the full word unless the optional feature below is enabled.
- Back-to-back: an accept in the completion (IDLE) cycle is legal; the next transfer starts with no lost cycles.

Optional Feature:
- Macro: AHBL_TO_APB_APB4_EN.
- Defined:
  - Adds ports apbm_pstrb output 4 and apbm_pprot output 3.
  - pstrb is decoded from the latched hsize/haddr[1:0]:
    - byte: 1<<a[1:0]
    - half: 3<<{a[1],0}
    - word: 4'hf
  - pstrb is forced to 0 on reads.
  - pprot = {~hprot[0], 1'b0, hprot[1]}, latched at accept.
  - pstrb and pprot reset to 0.
- Undefined: the ports are absent; behaviour is otherwise identical.

Decomposition:
- Package ahbl_apb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HSIZE_BYTE/HALF/WORD constants.
  - State enum (IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2).
  - Function calc_pstrb(hsize, addr_lsbs).
- No sub-module; a single FSM module.

Test Plan:
- Read 0x4000_0010, prdata=0xCAFEF00D, pready=1 first ACCESS -> paddr=0x0010, psel c1, penable c2, hready_resp=1 and hrdata=0xCAFEF00D in c3, hresp=0.
- Write 0x4000_0004, hwdata=0x12345678, pready held low 5 cycles in ACCESS -> pwdata=0x12345678 from SETUP onward; hready_resp low throughout; completes the cycle after pready.
- Read with pready=1, pslverr=1 -> ERR1 (hresp=1, hready_resp=0) then ERR2 (hresp=1, hready_resp=1); psel=0 in ERR1.
- Back-to-back NONSEQ write then read, second address in the completion cycle -> two APB transfers, one psel=0 cycle between, both OKAY.
- htrans=IDLE and BUSY with hready=1 for 10 cycles -> no psel, hready_resp=1, hresp=0 throughout.
- rst_n asserted during ACCESS -> psel/penable/hresp=0, hready_resp=1 asynchronously. A subsequent read (prdata=0xA5A5A5A5, pready=1) completes normally with hrdata=0xA5A5A5A5.
- With AHBL_TO_APB_APB4_EN: byte write to 0x...3 gives pstrb=4'b1000; a read gives pstrb=0.
